// File: rtl/run_ctrl.sv
// run_ctrl: sequences core reset/start for one host-requested run and reports its outcome
module run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        abort,
  input  logic        core_done,
  output logic        host_ack,
  output logic        core_reset,
  output logic        core_start,
  output logic        busy,
  output logic [15:0] cycle_count,
  output logic        timeout,
  output logic        aborted
);
  typedef enum logic [2:0] {IDLE, RST, START, RUN, REPORT} state_t;
  state_t      state, state_n;
  logic [3:0]  rc, rc_n;
  logic [15:0] cnt_n;
  logic        to_n, ab_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      rc          <= '0;
      cycle_count <= '0;
      timeout     <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_n;
      rc          <= rc_n;
      cycle_count <= cnt_n;
      timeout     <= to_n;
      aborted     <= ab_n;
    end
  always_comb begin
    state_n = state;
    rc_n    = rc;
    cnt_n   = cycle_count;
    to_n    = timeout;
    ab_n    = aborted;
    case (state)
      IDLE: if (host_req) begin
        state_n = RST;
        rc_n    = '0;
        cnt_n   = '0;
        to_n    = 1'b0;
        ab_n    = 1'b0;
      end
      RST:
        if (abort) begin
          state_n = REPORT;
          ab_n    = 1'b1;
        end else if (rc == 4'(RST_CYCLES - 1)) state_n = START;
        else rc_n = rc + 4'd1;
      START:
        if (abort) begin
          state_n = REPORT;
          ab_n    = 1'b1;
        end else state_n = RUN;
      RUN:
        if (core_done) state_n = REPORT;
        else if (abort) begin
          state_n = REPORT;
          ab_n    = 1'b1;
        end else begin
          cnt_n = cycle_count + 16'd1;
          if (cycle_count == 16'(MAX_CYCLES - 1)) begin
            state_n = REPORT;
            to_n    = 1'b1;
          end
        end
      REPORT: if (!host_req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign core_reset = !(state == START || state == RUN);
  assign core_start = state == START;
  assign busy       = state == RST || state == START || state == RUN;
  assign host_ack   = state == REPORT;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized and directed runs checked against an outcome model of run_ctrl
module tb_run_ctrl;
  localparam int R = 2;
  localparam int M = 20;
  localparam int NONE = 1000;
  logic clk = 1'b0, reset = 1'b0, host_req = 1'b0, abort = 1'b0, core_done = 1'b0;
  logic host_ack, core_reset, core_start, busy, timeout, aborted;
  logic [15:0] cycle_count;
  int checks = 0, errors = 0;
  logic [15:0] m_cnt = '0;
  logic m_to = 1'b0, m_ab = 1'b0;

  run_ctrl #(.RST_CYCLES(R), .MAX_CYCLES(M)) dut (
    .clk(clk), .reset(reset), .host_req(host_req), .abort(abort), .core_done(core_done),
    .host_ack(host_ack), .core_reset(core_reset), .core_start(core_start), .busy(busy),
    .cycle_count(cycle_count), .timeout(timeout), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ack, input logic cr, input logic cs,
                         input logic bz, input logic [15:0] cnt, input logic to, input logic ab);
    chk({tag, ".host_ack"}, 32'(host_ack), 32'(ack));
    chk({tag, ".core_reset"}, 32'(core_reset), 32'(cr));
    chk({tag, ".core_start"}, 32'(core_start), 32'(cs));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cnt));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
    chk({tag, ".aborted"}, 32'(aborted), 32'(ab));
  endtask

  // done_k: RUN cycle (1-based) where core_done rises; abort_ph: phase after acceptance
  // (RST=1..R, START=R+1, RUN k = R+1+k) where abort is high; req_len: phases host_req stays up;
  // extra: additional REPORT cycles with host_req held high.
  task automatic run_one(input int done_k, input int abort_ph, input int req_len, input int extra,
                         input string tag);
    int e, a, kend;
    logic [15:0] ec;
    logic eto, eab;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_out({tag, ".idle"}, 0, 1, 0, 0, m_cnt, m_to, m_ab);
      abort = 1'($urandom);
      core_done = 1'($urandom);
      host_req = (i == 1);
    end
    if (abort_ph <= R + 1) begin
      e = abort_ph; ec = '0; eto = 1'b0; eab = 1'b1;
    end else begin
      a = abort_ph - (R + 1);
      if (done_k <= a && done_k <= M) begin
        kend = done_k; ec = 16'(done_k - 1); eto = 1'b0; eab = 1'b0;
      end else if (a <= M) begin
        kend = a; ec = 16'(a - 1); eto = 1'b0; eab = 1'b1;
      end else begin
        kend = M; ec = 16'(M); eto = 1'b1; eab = 1'b0;
      end
      e = R + 1 + kend;
    end
    for (int p = 1; p <= e; p++) begin
      logic st, rn;
      @(negedge clk);
      st = (p == R + 1);
      rn = (p > R + 1);
      chk_out({tag, ".run"}, 0, !(st || rn), st, 1, rn ? 16'(p - R - 2) : 16'd0, 0, 0);
      host_req = (p < req_len);
      abort = (p == abort_ph);
      core_done = rn ? (p - R - 1 == done_k) : 1'($urandom);
    end
    m_cnt = ec; m_to = eto; m_ab = eab;
    for (int j = 0; j <= extra; j++) begin
      @(negedge clk);
      chk_out({tag, ".report"}, 1, 1, 0, 0, ec, eto, eab);
      host_req = (j < extra);
      abort = 1'($urandom);
      core_done = 1'($urandom);
    end
    @(negedge clk);
    chk_out({tag, ".done"}, 0, 1, 0, 0, ec, eto, eab);
    host_req = 1'b0; abort = 1'b0; core_done = 1'b0;
  endtask

  initial begin
    #2;
    chk_out("por", 0, 1, 0, 0, 16'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    run_one(5, NONE, NONE, 2, "normal");
    run_one(NONE, NONE, NONE, 0, "timeout");
    run_one(M, R + 1 + M, NONE, 1, "tie");
    run_one(NONE, 1, NONE, 0, "abort_rst");
    run_one(NONE, R + 1, NONE, 0, "abort_start");
    run_one(3, NONE, 1, 0, "early_drop");
    run_one(1, NONE, NONE, 0, "done_first");
    // reset while in RUN with cycle_count=7
    @(negedge clk);
    host_req = 1'b1;
    for (int p = 1; p <= R + 1 + 8; p++) begin
      @(negedge clk);
      host_req = 1'b0;
    end
    chk("midrun.cycle_count", 32'(cycle_count), 32'd7);
    #1 reset = 1'b0;
    #1 chk_out("midrun.async", 0, 1, 0, 0, 16'd0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    m_cnt = '0; m_to = 1'b0; m_ab = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_out("midrun.after", 0, 1, 0, 0, 16'd0, 0, 0);
    end
    run_one(5, NONE, NONE, 1, "post_reset");
    for (int n = 0; n < 40; n++)
      run_one($urandom_range(1, M + 3),
              ($urandom_range(0, 3) == 0) ? NONE : $urandom_range(1, R + 1 + M + 2),
              $urandom_range(1, R + M + 5), $urandom_range(0, 2), "rand");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of cycles the core is held in reset before a run (1..15).
REQ-002 SHALL have parameter MAX_CYCLES, default 16'hFFFF: RUN-cycle limit before timeout (1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port host_req  input  1  four-phase run request from the host.
REQ-006 SHALL have port abort  input  1  host abort request, sampled on clk.
REQ-007 SHALL have port core_done  input  1  done output of the processor top level.
REQ-008 SHALL have port host_ack  output  1  four-phase acknowledge; high means results are valid.
REQ-009 SHALL have port core_reset  output  1  active-high reset driven to the processor top level.
REQ-010 SHALL have port core_start  output  1  single-cycle start pulse to the processor top level.
REQ-011 SHALL have port busy  output  1  high in RST, START and RUN.
REQ-012 SHALL have port cycle_count  output  16  RUN cycles elapsed; frozen after the run ends.
REQ-013 SHALL have port timeout  output  1  last run ended by reaching MAX_CYCLES.
REQ-014 SHALL have port aborted  output  1  last run ended by abort.

Function
REQ-015 SHALL implement states IDLE, RST, START, RUN, REPORT, all registered; outputs SHALL be decoded from registered state and counters only, with no combinational input-to-output path.
REQ-016 IDLE: core_reset=1, core_start=0, host_ack=0; host_req=1 -> RST; reset the RST-cycle counter and clear timeout, aborted and cycle_count on that transition.
REQ-017 RST: core_reset=1 for exactly RST_CYCLES cycles -> START; abort=1 -> REPORT with aborted=1.
REQ-018 START: core_reset=0, core_start=1 for exactly one cycle -> RUN; abort=1 -> REPORT with aborted=1 (the start pulse is still issued that cycle).
REQ-019 RUN: core_reset=0, core_start=0; each cycle with core_done=0 and no abort, cycle_count increments by 1.
REQ-020 RUN exit priority, evaluated each cycle: core_done=1 -> REPORT (count not incremented); else abort=1 -> REPORT with aborted=1; else if cycle_count==MAX_CYCLES-1 -> REPORT with timeout=1 and cycle_count=MAX_CYCLES.
REQ-021 cycle_count SHALL never wrap; it saturates at MAX_CYCLES.
REQ-022 REPORT: core_reset=1, host_ack=1; cycle_count, timeout and aborted held; host_req=0 -> IDLE (host_ack falls on the same edge).
REQ-023 If host_req is already 0 on entry to REPORT, host_ack SHALL be high for exactly one cycle.
REQ-024 host_req deassertion during RST, START or RUN SHALL be ignored; the run completes normally.
REQ-025 core_done SHALL be ignored in every state except RUN.
REQ-026 abort SHALL be ignored in IDLE and REPORT.
REQ-027 timeout and aborted SHALL never both be 1.

Reset
REQ-028 On reset=0, asynchronously: state=IDLE, core_reset=1, core_start=0, host_ack=0, busy=0, cycle_count=0, timeout=0, aborted=0.
REQ-029 Reset asserted mid-run SHALL discard the run; no ack is generated for it after release.
REQ-030 Reset release SHALL be synchronous to clk; first transition possible on the first rising edge with reset=1.

Verification
REQ-031 Normal run (RST_CYCLES=2): host_req=1, core_done rises on the 5th RUN cycle -> core_reset high 2 cycles, core_start 1 cycle, cycle_count=4, timeout=0, aborted=0, host_ack=1 until host_req=0.
REQ-032 Timeout (MAX_CYCLES=20): core_done held 0 -> REPORT after 20 RUN cycles, cycle_count=20, timeout=1, busy falls the same edge.
REQ-033 Tie: core_done=1 and abort=1 in the same RUN cycle, with cycle_count=MAX_CYCLES-1 -> done wins, timeout=0, aborted=0, cycle_count=MAX_CYCLES-1.
REQ-034 Abort in RST on its 1st cycle -> REPORT next edge, aborted=1, core_start never pulses, cycle_count=0.
REQ-035 Early req drop: host_req pulsed high 1 cycle; core_done at RUN cycle 3 -> host_ack high exactly 1 cycle, then IDLE, cycle_count=2 held.
REQ-036 Reset mid-RUN at cycle_count=7 -> all outputs return to their reset values immediately, without waiting for clk; no ack after release; a following request behaves as in REQ-031.
